kbd_014: RTL and testbench

Keyboard controller for the BK-0010+ system, functionally a К1801ВП1-014. It is a bus slave on the inverted multiplexed CPU bus, alongside the RAM controller, ROM and system/palette ports. It buffers key codes from a host-side key source and exposes them through the status and data registers at 0177660 and 0177662. It requests vectored interrupts through `pin_virq_n` and answers the interrupt-acknowledge vector read.

---
 rtl/kbd_pkg.sv | 29 ++
 rtl/kbd_fifo.sv | 74 +++++++
 rtl/kbd_014.sv | 204 ++++++++++++++++++++
 tb/tb_kbd_014.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_pkg
// Description : Shared constants and types for the BK-0010+ keyboard
//               controller: register addresses, interrupt vectors, the bus
//               state encoding and the key-entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    localparam logic [15:0] KBD_ST_ADDR  = 16'o177660;
    localparam logic [15:0] KBD_DAT_ADDR = 16'o177662;
    localparam logic [15:0] KBD_VEC      = 16'o000060;
    localparam logic [15:0] KBD_VEC_AR2  = 16'o000274;

    typedef enum logic [1:0] {
        BUS_IDLE     = 2'd0,
        BUS_RD       = 2'd1,
        BUS_WR       = 2'd2,
        BUS_WAIT_END = 2'd3
    } bus_state_t;

    typedef struct packed {
        logic       ar2;
        logic [6:0] code;
    } kbd_entry_t;

endpackage : kbd_pkg
`default_nettype wire

// File: rtl/kbd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kbd_fifo
// Description : Small synchronous FIFO of key entries. A push while full is
//               accepted only when a pop happens on the same clock; otherwise
//               the new entry is dropped and the contents are untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  kbd_entry_t i_data,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output kbd_entry_t o_head
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = $clog2(DEPTH + 1);

    kbd_entry_t        r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic              w_pop_ok;
    logic              w_push_ok;

    // Wrapping pointer increment that works for any depth, including 1.
    function automatic logic [c_aw-1:0] f_next(input logic [c_aw-1:0] p);
        return (p == c_aw'(DEPTH - 1)) ? '0 : p + c_aw'(1);
    endfunction

    assign o_full    = (r_count == c_cw'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : kbd_fifo
`default_nettype wire

// File: rtl/kbd_014.sv
`default_nettype none
// ============================================================================
// Module      : kbd_014
// Description : BK-0010+ keyboard controller (K1801VP1-014 equivalent).
//               Bus slave for the status (0177660) and data (0177662)
//               registers on the inverted multiplexed bus, with a vectored
//               interrupt (0060, or 0274 for AR2 keys).
//               Build option KBD_FIFO_EN: when defined, keys are buffered in
//               a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_014
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              pin_clk,
    input  logic              pin_init_n,
    inout  wire logic [15:0]  pin_ad_n,
    input  logic              pin_sync_n,
    input  logic              pin_din_n,
    input  logic              pin_dout_n,
    input  logic              pin_wtbt_n,
    output wire logic         pin_rply_n,
    output logic              pin_virq_n,
    input  logic              pin_iako_n,
    input  logic              key_stb,
    input  logic [6:0]        key_code,
    input  logic              key_ar2
);

`ifdef KBD_FIFO_EN
    localparam int c_fifo_depth = FIFO_DEPTH;
`else
    localparam int c_fifo_depth = 1;
`endif

    // The buffer depth must be a power of two.
    if ((FIFO_DEPTH < 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("kbd_014: FIFO_DEPTH must be a power of two");
    end

    bus_state_t  r_state;
    logic        r_sync_prev;
    logic [15:0] r_addr;
    logic        r_rply;
    logic        r_drive;
    logic [15:0] r_rdata;
    logic        r_int_dis;
    logic        r_ack_done;
    logic [6:0]  r_last;
    logic        r_is_vec;
    logic        r_is_dat;
    logic        r_pop_pend;
    logic        r_wr_load;
    logic        r_wr_bit6;
    logic        r_virq_n;

    logic        w_sel_st;
    logic        w_sel_dat;
    logic        w_vec_cyc;
    logic        w_reg_cyc;
    logic        w_rd_go;
    logic        w_wr_go;
    logic        w_ready;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    kbd_entry_t  w_head;
    kbd_entry_t  w_key;
    logic [15:0] w_rdata;

    assign w_sel_st  = (r_addr[15:1] == KBD_ST_ADDR[15:1]);
    assign w_sel_dat = (r_addr[15:1] == KBD_DAT_ADDR[15:1]);
    // A vector cycle is only answered while our own request is active.
    assign w_vec_cyc = ~pin_iako_n & ~r_virq_n;
    assign w_reg_cyc = ~pin_sync_n & pin_iako_n;
    assign w_rd_go   = ~pin_din_n & (w_vec_cyc | (w_reg_cyc & (w_sel_st | w_sel_dat)));
    // Data-register writes belong to the palette port, so only status writes are taken.
    assign w_wr_go   = ~pin_dout_n & w_reg_cyc & w_sel_st;
    assign w_ready   = ~w_empty;
    // Pop happens on the DIN release edge of a data read that saw a non-empty buffer.
    assign w_pop     = (r_state == BUS_RD) & pin_din_n & r_pop_pend;
    assign w_push    = key_stb & (~w_full | w_pop);
    assign w_key     = '{ar2: key_ar2, code: key_code};

    kbd_fifo #(
        .DEPTH   (c_fifo_depth)
    ) u_fifo (
        .clk     (pin_clk),
        .rst_n   (pin_init_n),
        .i_push  (w_push),
        .i_data  (w_key),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Read data selected at the start of a read cycle.
    always_comb begin
        w_rdata = 16'h0000;
        if (w_vec_cyc) begin
            w_rdata = w_head.ar2 ? KBD_VEC_AR2 : KBD_VEC;
        end else if (w_sel_st) begin
            w_rdata = {8'h00, w_ready, r_int_dis, 6'h00};
        end else begin
            w_rdata = {9'h000, w_empty ? r_last : w_head.code};
        end
    end

    // Latch the address on the first clock that sees SYNC low.
    always_ff @(posedge pin_clk or negedge pin_init_n) begin
        if (!pin_init_n) begin
            r_sync_prev <= 1'b1;
            r_addr      <= 16'h0000;
        end else begin
            r_sync_prev <= pin_sync_n;
            if (r_sync_prev && !pin_sync_n) begin
                r_addr <= ~pin_ad_n;
            end
        end
    end

    // Bus cycle state machine with registered reply, data drive and interrupt request.
    always_ff @(posedge pin_clk or negedge pin_init_n) begin
        if (!pin_init_n) begin
            r_state    <= BUS_IDLE;
            r_rply     <= 1'b0;
            r_drive    <= 1'b0;
            r_rdata    <= 16'h0000;
            r_int_dis  <= 1'b0;
            r_ack_done <= 1'b0;
            r_last     <= 7'h00;
            r_is_vec   <= 1'b0;
            r_is_dat   <= 1'b0;
            r_pop_pend <= 1'b0;
            r_wr_load  <= 1'b0;
            r_wr_bit6  <= 1'b0;
            r_virq_n   <= 1'b1;
        end else begin
            r_virq_n <= ~(w_ready & ~r_int_dis & ~r_ack_done);
            case (r_state)
                BUS_IDLE: begin
                    if (w_rd_go) begin
                        r_state    <= BUS_RD;
                        r_rply     <= 1'b1;
                        r_drive    <= 1'b1;
                        r_rdata    <= w_rdata;
                        r_is_vec   <= w_vec_cyc;
                        r_is_dat   <= ~w_vec_cyc & w_sel_dat;
                        // An empty buffer at read start returns the stale code and must not pop
                        // a key that arrives during the cycle.
                        r_pop_pend <= ~w_vec_cyc & w_sel_dat & ~w_empty;
                    end else if (w_wr_go) begin
                        r_state   <= BUS_WR;
                        r_rply    <= 1'b1;
                        // A byte write to the odd address carries no status bits.
                        r_wr_load <= ~(~pin_wtbt_n & r_addr[0]);
                        r_wr_bit6 <= ~pin_ad_n[6];
                    end
                end
                BUS_RD: begin
                    if (pin_din_n) begin
                        r_state <= BUS_WAIT_END;
                        r_rply  <= 1'b0;
                        r_drive <= 1'b0;
                        if (r_is_vec) begin
                            r_ack_done <= 1'b1;
                        end
                        if (r_is_dat) begin
                            r_ack_done <= 1'b0;
                        end
                        if (r_pop_pend) begin
                            r_last <= w_head.code;
                        end
                    end
                end
                BUS_WR: begin
                    if (pin_dout_n) begin
                        r_state <= BUS_WAIT_END;
                        r_rply  <= 1'b0;
                        if (r_wr_load) begin
                            r_int_dis <= r_wr_bit6;
                        end
                    end
                end
                BUS_WAIT_END: begin
                    r_state <= BUS_IDLE;
                end
                default: begin
                    r_state <= BUS_IDLE;
                end
            endcase
        end
    end

    assign pin_rply_n = r_rply  ? 1'b0     : 1'bz;
    assign pin_ad_n   = r_drive ? ~r_rdata : 16'hzzzz;
    assign pin_virq_n = r_virq_n;

endmodule : kbd_014
`default_nettype wire

// File: tb/tb_kbd_014.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_014
// Description : Directed self-checking bench for the keyboard controller:
//               status/data reads, vector cycles, int_dis, dropped writes,
//               simultaneous key/read events and reset in mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_014;

    localparam logic [15:0] c_st  = 16'o177660;
    localparam logic [15:0] c_dat = 16'o177662;

    logic        clk;
    logic        init_n;
    logic        sync_n;
    logic        din_n;
    logic        dout_n;
    logic        wtbt_n;
    logic        iako_n;
    logic        key_stb;
    logic [6:0]  key_code;
    logic        key_ar2;
    logic        tb_drv;
    logic [15:0] tb_ad;
    tri1  [15:0] ad_n;
    tri1         rply_n;
    wire         virq_n;

    int          n_chk;
    int          n_fail;
    logic [15:0] rd;
    logic        got;
    logic [15:0] exp_last;

    assign ad_n = tb_drv ? tb_ad : 16'hzzzz;

    kbd_014 #(
        .FIFO_DEPTH (4)
    ) dut (
        .pin_clk    (clk),
        .pin_init_n (init_n),
        .pin_ad_n   (ad_n),
        .pin_sync_n (sync_n),
        .pin_din_n  (din_n),
        .pin_dout_n (dout_n),
        .pin_wtbt_n (wtbt_n),
        .pin_rply_n (rply_n),
        .pin_virq_n (virq_n),
        .pin_iako_n (iako_n),
        .key_stb    (key_stb),
        .key_code   (key_code),
        .key_ar2    (key_ar2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got_v, input logic [15:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %06o expected %06o", tag, got_v, exp_v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key_push(input logic [6:0] code, input logic ar2);
        @(negedge clk);
        key_stb  = 1'b1;
        key_code = code;
        key_ar2  = ar2;
        @(negedge clk);
        key_stb  = 1'b0;
    endtask

    // inj: 0 none, 1 key strobe with DIN assertion, 2 key strobe with DIN release
    task automatic bus_rd(input logic [15:0] addr, input int inj, input logic [6:0] icode,
                          output logic [15:0] data);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        tb_drv = 1'b1;
        tb_ad  = ~addr;
        sync_n = 1'b0;
        @(negedge clk);
        tb_drv = 1'b0;
        din_n  = 1'b0;
        if (inj == 1) begin
            key_stb  = 1'b1;
            key_code = icode;
            key_ar2  = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            key_stb = 1'b0;
            if (rply_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        data = ~ad_n;
        chk("rd_rply", 16'(ok), 16'd1);
        din_n = 1'b1;
        if (inj == 2) begin
            key_stb  = 1'b1;
            key_code = icode;
            key_ar2  = 1'b0;
        end
        @(negedge clk);
        key_stb = 1'b0;
        sync_n  = 1'b1;
        chk("rd_release", 16'(rply_n), 16'd1);
    endtask

    task automatic bus_wr(input logic [15:0] addr, input logic [15:0] data, input logic is_byte,
                          output logic ok);
        ok = 1'b0;
        @(negedge clk);
        tb_drv = 1'b1;
        tb_ad  = ~addr;
        sync_n = 1'b0;
        @(negedge clk);
        tb_ad  = ~data;
        wtbt_n = ~is_byte;
        dout_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rply_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        dout_n = 1'b1;
        @(negedge clk);
        tb_drv = 1'b0;
        sync_n = 1'b1;
        wtbt_n = 1'b1;
    endtask

    task automatic vec_rd(output logic [15:0] data);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        iako_n = 1'b0;
        din_n  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rply_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        data = ~ad_n;
        chk("vec_rply", 16'(ok), 16'd1);
        din_n  = 1'b1;
        iako_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        init_n   = 1'b0;
        sync_n   = 1'b1;
        din_n    = 1'b1;
        dout_n   = 1'b1;
        wtbt_n   = 1'b1;
        iako_n   = 1'b1;
        key_stb  = 1'b0;
        key_code = 7'h00;
        key_ar2  = 1'b0;
        tb_drv   = 1'b0;
        tb_ad    = 16'hffff;

        // Reset state
        idle(3);
        chk("rst_virq", 16'(virq_n), 16'd1);
        chk("rst_rply", 16'(rply_n), 16'd1);
        chk("rst_bus", ad_n, 16'hffff);
        init_n = 1'b1;
        idle(2);
        bus_rd(c_st, 0, 7'h00, rd);
        chk("rst_status", rd, 16'o000000);
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("rst_last_code", rd, 16'o000000);
        chk("rst_virq_idle", 16'(virq_n), 16'd1);

        // Plain key, vector 0060, data pop
        key_push(7'o101, 1'b0);
        bus_rd(c_st, 0, 7'h00, rd);
        chk("key1_status", rd, 16'o000200);
        chk("key1_virq", 16'(virq_n), 16'd0);
        vec_rd(rd);
        chk("key1_vector", rd, 16'o000060);
        idle(2);
        chk("key1_virq_ack", 16'(virq_n), 16'd1);
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("key1_data", rd, 16'o000101);
        bus_rd(c_st, 0, 7'h00, rd);
        chk("key1_status_after", rd, 16'o000000);

        // Interrupt disable, AR2 vector
        bus_wr(c_st, 16'o000100, 1'b0, got);
        chk("intdis_wr_rply", 16'(got), 16'd1);
        key_push(7'o015, 1'b1);
        idle(3);
        chk("intdis_no_virq", 16'(virq_n), 16'd1);
        bus_rd(c_st, 0, 7'h00, rd);
        chk("intdis_status", rd, 16'o000300);
        bus_wr(c_st, 16'o000000, 1'b0, got);
        idle(2);
        chk("inten_virq", 16'(virq_n), 16'd0);
        vec_rd(rd);
        chk("ar2_vector", rd, 16'o000274);
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("ar2_data", rd, 16'o000015);

        // Empty data read returns the last popped code
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("empty_data_stale", rd, 16'o000015);
        bus_rd(c_st, 0, 7'h00, rd);
        chk("empty_status", rd, 16'o000000);

        // Byte write to the odd status address: acknowledged, no effect
        bus_wr(16'o177661, 16'o040000, 1'b1, got);
        chk("odd_byte_rply", 16'(got), 16'd1);
        bus_rd(c_st, 0, 7'h00, rd);
        chk("odd_byte_status", rd, 16'o000000);

        // VIRQ timing: high one clock after the strobe, low after two
        @(negedge clk);
        key_stb  = 1'b1;
        key_code = 7'o042;
        key_ar2  = 1'b0;
        @(negedge clk);
        key_stb  = 1'b0;
        chk("virq_t1", 16'(virq_n), 16'd1);
        @(negedge clk);
        chk("virq_t2", 16'(virq_n), 16'd0);

        // Data-register write is not acknowledged and leaves the buffer alone
        bus_wr(c_dat, 16'o000123, 1'b0, got);
        chk("dat_wr_no_rply", 16'(got), 16'd0);
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("dat_wr_buf", rd, 16'o000042);

        // Second key while the first is still pending
        key_push(7'o011, 1'b0);
        key_push(7'o012, 1'b0);
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("two_keys_first", rd, 16'o000011);
`ifdef KBD_FIFO_EN
        bus_rd(c_st, 0, 7'h00, rd);
        chk("two_keys_status", rd, 16'o000200);
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("two_keys_second", rd, 16'o000012);
        exp_last = 16'o000012;
`else
        exp_last = 16'o000011;
`endif
        bus_rd(c_st, 0, 7'h00, rd);
        chk("two_keys_drained", rd, 16'o000000);

        // Key into an empty buffer together with a data read
        bus_rd(c_dat, 1, 7'o055, rd);
        chk("sim_empty_stale", rd, exp_last);
        bus_rd(c_st, 0, 7'h00, rd);
        chk("sim_empty_kept", rd, 16'o000200);
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("sim_empty_key", rd, 16'o000055);

        // Key together with a pop (full buffer in the single-register build)
        key_push(7'o021, 1'b0);
        bus_rd(c_dat, 2, 7'o022, rd);
        chk("sim_pop_head", rd, 16'o000021);
        bus_rd(c_st, 0, 7'h00, rd);
        chk("sim_pop_status", rd, 16'o000200);
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("sim_pop_new", rd, 16'o000022);
        bus_rd(c_st, 0, 7'h00, rd);
        chk("sim_pop_empty", rd, 16'o000000);

`ifdef KBD_FIFO_EN
        // Overfill a 4-deep buffer
        for (int k = 1; k <= 5; k++) begin
            key_push(7'(k), 1'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            bus_rd(c_dat, 0, 7'h00, rd);
            chk("fifo_order", rd, 16'(k));
        end
        bus_rd(c_st, 0, 7'h00, rd);
        chk("fifo_empty", rd, 16'o000000);
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("fifo_stale", rd, 16'o000004);
`endif

        // Reset in the middle of a read cycle
        key_push(7'o077, 1'b0);
        @(negedge clk);
        tb_drv = 1'b1;
        tb_ad  = ~c_dat;
        sync_n = 1'b0;
        @(negedge clk);
        tb_drv = 1'b0;
        din_n  = 1'b0;
        @(negedge clk);
        chk("midrst_rply_on", 16'(rply_n), 16'd0);
        init_n = 1'b0;
        #1;
        chk("midrst_rply_off", 16'(rply_n), 16'd1);
        chk("midrst_bus_off", ad_n, 16'hffff);
        chk("midrst_virq", 16'(virq_n), 16'd1);
        @(negedge clk);
        din_n  = 1'b1;
        sync_n = 1'b1;
        @(negedge clk);
        init_n = 1'b1;
        idle(2);
        bus_rd(c_st, 0, 7'h00, rd);
        chk("midrst_status", rd, 16'o000000);
        bus_rd(c_dat, 0, 7'h00, rd);
        chk("midrst_last", rd, 16'o000000);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_kbd_014
`default_nettype wire
